rle_decoder: RTL and testbench
==============================

# rle_decoder

Run-length decoder that sits directly downstream of the capture core's RLE encoder. It consumes the encoder's output word stream and re-expands it into one masked sample per original sample clock. It is used on the readback path to reconstruct raw samples from RLE-compressed captures. It is also used as a synthesizable reference model so benches can compare a reconstructed stream against the stimulus.

## Interface
Parameters:
- `DW`, default 32: data word width. Only 32 is supported.
- `CW`, default 31: remaining-count register width. Must be ≥ 31 so a mode-3 count fits.

Ports:
- `clock` — in, 1: the single clock; every register is clocked on its rising edge.
- `reset_n` — in, 1: reset, asynchronous and active-low.
- `enable` — in, 1: 1 = decode, 0 = pass-through.
- `mode` — in, 2: flag bit position (0→bit 7, 1→bit 15, 2→bit 23, 3→bit 31). The count field is all bits below the flag.
- `rle_repeat_mode` — in, 1: 1 = count is inclusive of the data word already emitted.
- `data_mask` — in, DW: AND-mask applied to data words before output.
- `clear` — in, 1: synchronous abort.
- `validIn` — in, 1: input word valid.
- `dataIn` — in, DW: encoded input word.
- `readyIn` — out, 1: decoder can accept an input word this cycle.
- `validOut` — out, 1: output sample valid.
- `dataOut` — out, DW: decoded sample.
- `readyOut` — in, 1: downstream accepts the output sample.
- `busy` — out, 1: state is not IDLE, or an output beat is pending.
- `count_err` — out, 1: sticky flag; a count word arrived with no preceding data word.

## Operation
- Input handshake: a word is accepted on a rising edge where `validIn && readyIn`.
- Output handshake: a beat completes on a rising edge where `validOut && readyOut`. `dataOut` and `validOut` hold stable until the beat completes.
- `readyIn` = `reset_n && state!=REPEAT && (!validOut || readyOut)`.
- `flag` = `dataIn[8*mode+7]`. `cnt` = `dataIn` bits below the flag, zero-extended to CW.
- States:
  - IDLE: no last value held.
  - HOLD: last value held; the decoder accepts new words.
  - REPEAT: emitting repeats; no input is accepted.
- `mode`, `rle_repeat_mode` and `data_mask` are sampled on each accepted word. Changing them mid-REPEAT does not affect the repeats already in progress.
- Data word (`flag`=0, or `enable`=0):
  - `last` ← `dataIn & data_mask`.
  - One output beat of `last`.
  - State → HOLD.
- `enable`=0 (pass-through): every accepted word is output unmodified, with no mask applied. `last` still updates, so decoding can resume seamlessly.
- Count word (`flag`=1, `enable`=1):
  - Repeat total N = `cnt`. If `rle_repeat_mode`, N = `cnt`−1, saturating at 0.
  - N=0: no output; state is unchanged; the word is consumed.
  - N≥1 in HOLD: output beat of `last` loaded; `remaining` ← N−1. State → REPEAT if N−1>0, else stays HOLD.
  - Any count word in IDLE: dropped with no output; `count_err` ← 1.
- In REPEAT: on each completed output beat, if `remaining`>0, reload the beat with `last` and decrement `remaining`. When `remaining` reaches 0, state → HOLD.
- `clear`: on the next edge, state → IDLE, `validOut` ← 0, `remaining` ← 0, `count_err` ← 0.
  - The pending beat is discarded.
  - `clear` has priority over a simultaneous input accept; that input word is lost.

## Timing
- Reset values: `validOut`=0, `dataOut`=0, `count_err`=0, `busy`=0, state IDLE, `remaining`=0, `last`=0. `readyIn`=0 while `reset_n` is low.
- Data word accepted at edge t → `validOut`=1 with that value after edge t.
- Count N accepted at edge t with `readyOut` held high:
  - N consecutive beats, presented from edge t through edge t+N−1.
  - `readyIn` is low while state=REPEAT.
  - The next input is accepted at edge t+N, back-to-back with the last beat.
- Full throughput is 1 input/cycle for data words while `readyOut`=1. There are no bubbles on the output during repeats.
- `readyOut` low stalls everything. `remaining` does not decrement while a beat is stalled.
- The count field decodes exactly at every width, e.g. mode 0 max 127, mode 3 max 2^31−1. The counter never wraps.
- `reset_n` asserted mid-REPEAT clears all state immediately (asynchronous). The first accept after deassertion lands in IDLE.

## Test plan
- Basic repeat, mode 0, `rle_repeat_mode`=0, mask all ones: inputs 0x05, 0x83, 0x06 → outputs 0x05 ×4 then 0x06; `count_err`=0.
- Inclusive repeat, mode 3, `rle_repeat_mode`=1: inputs 0x0000_0001, 0x8000_0003 → 0x1 ×3 in total. A following count word 0x8000_0001 (N=0) produces no output.
- Error and clear: after reset, input count word 0x85 → no output, `count_err`=1. Pulse `clear` → `count_err`=0.
- Backpressure, mode 1: input 0x0042 then 0x8005. Toggle `readyOut` pseudo-randomly → exactly 6 beats of 0x0042, each held stable while stalled. `readyIn` stays low until the 6th beat is presented.
- Reset mid-REPEAT: 0x11 then 0xFF (127 repeats). Assert `reset_n` after 10 beats → `validOut`=0 immediately. Then 0x9 after reset → a single 0x9 beat.
- Mask and pass-through:
  - `data_mask`=0x07, input 0x3D → 0x05.
  - Set `enable`=0 and input 0x85 → a single 0x85 beat, not a repeat.

Source files
------------

// File: rtl/rle_decoder.sv
// rle_decoder: re-expands an RLE word stream (data words + count words)
// into one masked sample per original sample, with valid/ready on both sides.
module rle_decoder #(
    parameter int DW = 32,
    parameter int CW = 31
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic          rle_repeat_mode,
    input  logic [DW-1:0] data_mask,
    input  logic          clear,
    input  logic          validIn,
    input  logic [DW-1:0] dataIn,
    output logic          readyIn,
    output logic          validOut,
    output logic [DW-1:0] dataOut,
    input  logic          readyOut,
    output logic          busy,
    output logic          count_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_last;
    logic [DW-1:0] w_last_nxt;
    logic [CW-1:0] r_remaining;
    logic [CW-1:0] w_remaining_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic [DW-1:0] r_data;
    logic [DW-1:0] w_data_nxt;
    logic          r_count_err;
    logic          w_count_err_nxt;

    logic          w_flag;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_n;
    logic          w_accept;
    logic          w_beat_done;
    logic [DW-1:0] w_masked;

    assign readyIn     = reset_n && (r_state != ST_REPEAT) && (!r_valid || readyOut);
    assign w_accept    = validIn && readyIn;
    assign w_beat_done = r_valid && readyOut;
    assign w_masked    = dataIn & data_mask;

    assign validOut  = r_valid;
    assign dataOut   = r_data;
    assign count_err = r_count_err;
    assign busy      = (r_state != ST_IDLE) || r_valid;

    // Split the input word into flag bit and count field according to mode,
    // then derive the repeat total N (inclusive mode saturates at zero).
    always_comb begin
        w_flag = 1'b0;
        w_cnt  = '0;
        case (mode)
            2'd0: begin
                w_flag     = dataIn[7];
                w_cnt[6:0] = dataIn[6:0];
            end
            2'd1: begin
                w_flag      = dataIn[15];
                w_cnt[14:0] = dataIn[14:0];
            end
            2'd2: begin
                w_flag      = dataIn[23];
                w_cnt[22:0] = dataIn[22:0];
            end
            default: begin
                w_flag      = dataIn[31];
                w_cnt[30:0] = dataIn[30:0];
            end
        endcase
        if (rle_repeat_mode) begin
            w_n = (w_cnt == '0) ? '0 : (w_cnt - CW'(1));
        end else begin
            w_n = w_cnt;
        end
    end

    // Next-state and output-beat logic; clear overrides everything, repeat
    // reload and input accept are mutually exclusive since readyIn is low in REPEAT.
    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_remaining_nxt = r_remaining;
        w_valid_nxt     = r_valid;
        w_data_nxt      = r_data;
        w_count_err_nxt = r_count_err;

        if (clear) begin
            w_state_nxt     = ST_IDLE;
            w_valid_nxt     = 1'b0;
            w_remaining_nxt = '0;
            w_count_err_nxt = 1'b0;
        end else begin
            if (w_beat_done) begin
                w_valid_nxt = 1'b0;
            end

            if ((r_state == ST_REPEAT) && w_beat_done) begin
                if (r_remaining != '0) begin
                    w_valid_nxt     = 1'b1;
                    w_data_nxt      = r_last;
                    w_remaining_nxt = r_remaining - CW'(1);
                    if (r_remaining == CW'(1)) begin
                        w_state_nxt = ST_HOLD;
                    end
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end

            if (w_accept) begin
                if (!enable || !w_flag) begin
                    w_last_nxt  = w_masked;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = enable ? w_masked : dataIn;
                    w_state_nxt = ST_HOLD;
                end else if (r_state == ST_IDLE) begin
                    w_count_err_nxt = 1'b1;
                end else if (w_n != '0) begin
                    w_valid_nxt     = 1'b1;
                    w_data_nxt      = r_last;
                    w_remaining_nxt = w_n - CW'(1);
                    w_state_nxt     = (w_n == CW'(1)) ? ST_HOLD : ST_REPEAT;
                end
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_last      <= '0;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_count_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_remaining <= w_remaining_nxt;
            r_valid     <= w_valid_nxt;
            r_data      <= w_data_nxt;
            r_count_err <= w_count_err_nxt;
        end
    end

endmodule

// File: tb/tb_rle_decoder.sv
// Directed bench for rle_decoder with an expected-beat queue.
module tb_rle_decoder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        rle_repeat_mode = 1'b0;
    logic [31:0] data_mask = 32'hFFFF_FFFF;
    logic        clear = 1'b0;
    logic        validIn = 1'b0;
    logic [31:0] dataIn = '0;
    logic        readyIn;
    logic        validOut;
    logic [31:0] dataOut;
    logic        readyOut = 1'b1;
    logic        busy;
    logic        count_err;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned beat_cnt = 0;
    logic [31:0] q[$];
    logic        stalled = 1'b0;
    logic [31:0] held = '0;

    rle_decoder #(.DW(32), .CW(31)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
        .rle_repeat_mode(rle_repeat_mode), .data_mask(data_mask), .clear(clear),
        .validIn(validIn), .dataIn(dataIn), .readyIn(readyIn),
        .validOut(validOut), .dataOut(dataOut), .readyOut(readyOut),
        .busy(busy), .count_err(count_err)
    );

    always #5 clock = ~clock;

    // Output monitor: compare each completing beat against the queue head
    // and verify stalled beats stay stable.
    always @(negedge clock) begin
        if (!reset_n || !validOut) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                assert (dataOut === held) else begin
                    errors++;
                    $error("FAIL stall_hold: observed 0x%0h expected 0x%0h", dataOut, held);
                end
            end
            if (readyOut) begin
                checks++;
                assert (q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat: observed 0x%0h expected none", dataOut);
                end
                if (q.size() != 0) begin
                    logic [31:0] exp;
                    exp = q.pop_front();
                    checks++;
                    assert (dataOut === exp) else begin
                        errors++;
                        $error("FAIL beat_data: observed 0x%0h expected 0x%0h", dataOut, exp);
                    end
                end
                beat_cnt++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = dataOut;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_n(input logic [31:0] v, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) q.push_back(v);
    endtask

    task automatic send(input logic [31:0] w);
        int unsigned n;
        n = 0;
        validIn = 1'b1;
        dataIn  = w;
        @(negedge clock);
        while (!readyIn && n < 1000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        assert (readyIn === 1'b1) else begin
            errors++;
            $error("FAIL send_timeout: observed readyIn=%0b expected 1", readyIn);
        end
        @(posedge clock);
        #1;
        validIn = 1'b0;
    endtask

    // Wait for queue and output to empty; optional random backpressure and
    // a readyIn check until `ri_gate` beats (counted from `base`) have completed.
    task automatic drain(input bit rnd, input bit ri_chk, input int unsigned base,
                         input int unsigned ri_gate);
        for (int unsigned c = 0; c < 2000; c++) begin
            @(posedge clock);
            #1;
            if (rnd) readyOut = 1'($urandom_range(0, 1));
            #1;
            if (ri_chk && (beat_cnt - base) < ri_gate) chk("readyIn_low_repeat", 32'(readyIn), 32'd0);
            if (q.size() == 0 && !validOut) break;
        end
        readyOut = 1'b1;
        checks++;
        assert (q.size() == 0 && validOut === 1'b0) else begin
            errors++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", q.size());
        end
    endtask

    task automatic idle_cycles(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_beats(input int unsigned base, input int unsigned n);
        for (int unsigned c = 0; c < 500; c++) begin
            @(posedge clock);
            #1;
            if (beat_cnt - base >= n) break;
        end
        checks++;
        assert (beat_cnt - base >= n) else begin
            errors++;
            $error("FAIL beat_wait: observed %0d beats expected %0d", beat_cnt - base, n);
        end
    endtask

    initial begin
        int unsigned base;

        // Reset values
        #12;
        chk("rst_validOut", 32'(validOut), 32'd0);
        chk("rst_dataOut", dataOut, 32'd0);
        chk("rst_count_err", 32'(count_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_readyIn", 32'(readyIn), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("post_rst_readyIn", 32'(readyIn), 32'd1);

        // Count word in IDLE: dropped, sticky error, then clear
        send(32'h85);
        idle_cycles(3);
        chk("err_flag", 32'(count_err), 32'd1);
        chk("err_no_output", 32'(validOut), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        chk("clear_err", 32'(count_err), 32'd0);

        // Basic repeat, mode 0
        push_n(32'h05, 1);
        send(32'h05);
        chk("data_latency_valid", 32'(validOut), 32'd1);
        chk("data_latency_value", dataOut, 32'h05);
        push_n(32'h05, 3);
        send(32'h83);
        chk("count_readyIn_low", 32'(readyIn), 32'd0);
        push_n(32'h06, 1);
        send(32'h06);
        drain(1'b0, 1'b0, 0, 0);
        chk("basic_count_err", 32'(count_err), 32'd0);

        // Inclusive repeat, mode 3, then N=0 count word
        mode = 2'd3;
        rle_repeat_mode = 1'b1;
        push_n(32'h1, 3);
        send(32'h0000_0001);
        send(32'h8000_0003);
        drain(1'b0, 1'b0, 0, 0);
        send(32'h8000_0001);
        idle_cycles(4);
        chk("n0_no_output", 32'(validOut), 32'd0);
        chk("n0_count_err", 32'(count_err), 32'd0);

        // Backpressure, mode 1: six beats of 0x0042
        mode = 2'd1;
        rle_repeat_mode = 1'b0;
        base = beat_cnt;
        push_n(32'h0042, 6);
        send(32'h0042);
        send(32'h8005);
        drain(1'b1, 1'b1, base, 5);
        chk("bp_beat_total", beat_cnt - base, 32'd6);

        // Mask and pass-through
        mode = 2'd0;
        data_mask = 32'h07;
        push_n(32'h05, 1);
        send(32'h3D);
        drain(1'b0, 1'b0, 0, 0);
        enable = 1'b0;
        base = beat_cnt;
        push_n(32'h85, 1);
        send(32'h85);
        drain(1'b0, 1'b0, 0, 0);
        idle_cycles(3);
        chk("passthru_single_beat", beat_cnt - base, 32'd1);
        enable = 1'b1;
        data_mask = 32'hFFFF_FFFF;

        // Clear mid-REPEAT discards the rest
        base = beat_cnt;
        push_n(32'h22, 5);
        send(32'h22);
        send(32'h84);
        wait_beats(base, 2);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        chk("clear_validOut", 32'(validOut), 32'd0);
        chk("clear_busy", 32'(busy), 32'd0);
        q.delete();

        // Reset mid-REPEAT, mode 0 max count
        base = beat_cnt;
        push_n(32'h11, 128);
        send(32'h11);
        send(32'hFF);
        wait_beats(base, 10);
        reset_n = 1'b0;
        #1;
        chk("arst_validOut", 32'(validOut), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_readyIn", 32'(readyIn), 32'd0);
        q.delete();
        idle_cycles(2);
        reset_n = 1'b1;
        base = beat_cnt;
        push_n(32'h9, 1);
        send(32'h9);
        drain(1'b0, 1'b0, 0, 0);
        idle_cycles(3);
        chk("post_arst_single", beat_cnt - base, 32'd1);
        chk("post_arst_count_err", 32'(count_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
